div_rem_unit: RTL and testbench

- Parametrised iterative divide/remainder accelerator for the RV32M execution stage; services DIV, DIVU, REM and REMU.
- Execution stage holds the operands and order stable while it stalls on `active && !ready`, and samples `result` in the cycle `ready` is high.
- Successor to the fixed 32-bit divider. Adds configurable width and radix, an early-out path, one-cycle special cases, a last-result cache (so DIV followed by REM on the same operands returns at zero latency) and a kill/abort path.

---
 rtl/div_rem_pkg.sv | 16 +
 rtl/div_rem_step.sv | 27 ++
 rtl/div_rem_unit.sv | 126 ++++++++++++
 tb/tb_div_rem_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_rem_pkg.sv
// div_rem_pkg: shared order encodings, FSM states and constants for the divider
package div_rem_pkg;
  localparam logic [1:0] ORD_DIV  = 2'b00;
  localparam logic [1:0] ORD_DIVU = 2'b01;
  localparam logic [1:0] ORD_REM  = 2'b10;
  localparam logic [1:0] ORD_REMU = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;
  // most negative signed value of an xlen-bit word, right-aligned in 64 bits
  function automatic logic [63:0] min_val(int xlen);
    return 64'd1 << (xlen - 1);
  endfunction
  // quotient produced on divide-by-zero: all ones at xlen bits
  function automatic logic [63:0] dbz_val(int xlen);
    return {64{1'b1}} >> (64 - xlen);
  endfunction
endpackage

// File: rtl/div_rem_step.sv
// div_rem_step: BPC chained restoring-subtract slices of an unsigned divider
module div_rem_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  // quo carries the unconsumed dividend bits in its top and collects quotient bits at the bottom
  logic [XLEN-1:0] r [BPC+1];
  logic [XLEN-1:0] q [BPC+1];
  assign r[0] = rem_i;
  assign q[0] = quo_i;
  for (genvar i = 0; i < BPC; i++) begin : g_slice
    logic [XLEN:0] t;
    logic ge;
    assign t = {r[i], q[i][XLEN-1]};
    assign ge = t >= {1'b0, div_i};
    assign r[i+1] = ge ? XLEN'(t - {1'b0, div_i}) : t[XLEN-1:0];
    assign q[i+1] = {q[i][XLEN-2:0], ge};
  end
  assign rem_o = r[BPC];
  assign quo_o = q[BPC];
endmodule

// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative RV32M DIV/DIVU/REM/REMU unit with special cases, early-out, result cache and kill
module div_rem_unit
  import div_rem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] acc_in_A,
  input  logic [XLEN-1:0] acc_in_B,
  input  logic [1:0]      div_rem_order,
  input  logic            div_rem_order_active,
  input  logic            kill,
  output logic            div_rem_ready,
  output logic [XLEN-1:0] div_rem_result,
  output logic            busy
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN = XLEN'(min_val(XLEN));
  localparam logic [XLEN-1:0] DBZ = XLEN'(dbz_val(XLEN));
  state_e state_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, div_q, ca_q, cb_q, cq_q, cr_q;
  logic [XLEN-1:0] rem_d, quo_d, abs_a, abs_b;
  logic [1:0] ord_q;
  logic sgn_q, qneg_q, rneg_q, cu_q, cv_q, hit;
  logic [CW-1:0] cnt_q;
  div_rem_step #(.XLEN(XLEN), .BPC(BITS_PER_CYCLE)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );
  // magnitudes of the latched operands and the zero-latency cache lookup
  always_comb begin
    abs_a = (sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
    abs_b = (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
    hit = state_q == S_IDLE && div_rem_order_active && !kill && cv_q &&
          acc_in_A == ca_q && acc_in_B == cb_q && div_rem_order[0] == cu_q;
    div_rem_ready = hit || (state_q == S_DONE && !kill);
    div_rem_result = hit ? (div_rem_order[1] ? cr_q : cq_q) :
                     state_q == S_DONE ? (ord_q[1] ? rem_q : quo_q) : '0;
    busy = state_q != S_IDLE;
  end
  // control FSM, datapath registers and last-result cache
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      ord_q <= '0;
      sgn_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q <= '0;
      ca_q <= '0;
      cb_q <= '0;
      cq_q <= '0;
      cr_q <= '0;
      cu_q <= 1'b0;
      cv_q <= 1'b0;
    end else if (kill) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (div_rem_order_active && !hit) begin
          a_q <= acc_in_A;
          b_q <= acc_in_B;
          ord_q <= div_rem_order;
          sgn_q <= !div_rem_order[0];
          if (acc_in_B == '0) begin
            quo_q <= DBZ;
            rem_q <= acc_in_A;
            state_q <= S_DONE;
          end else if (!div_rem_order[0] && acc_in_A == MIN && acc_in_B == '1) begin
            quo_q <= MIN;
            rem_q <= '0;
            state_q <= S_DONE;
          end else state_q <= S_PREP;
        end
        S_PREP: begin
          qneg_q <= sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_q <= sgn_q & a_q[XLEN-1];
          div_q <= abs_b;
          if (EARLY_OUT != 0 && abs_a < abs_b) begin
            quo_q <= '0;
            rem_q <= abs_a;
            state_q <= S_FIX;
          end else begin
            quo_q <= abs_a;
            rem_q <= '0;
            cnt_q <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quo_q <= qneg_q ? -quo_q : quo_q;
          rem_q <= rneg_q ? -rem_q : rem_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ca_q <= a_q;
          cb_q <= b_q;
          cu_q <= ord_q[0];
          cq_q <= quo_q;
          cr_q <= rem_q;
          cv_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_rem_unit.sv
// tb_div_rem_unit: scoreboard bench for two divider configurations against a plain-arithmetic model
module tb_div_rem_unit;
  import div_rem_pkg::*;
  typedef struct {logic [31:0] v; int at;} exp_t;
  logic clk = 0, reset = 1;
  logic [31:0] a_in [2], b_in [2], res [2];
  logic [1:0] o_in [2];
  logic act [2], kil [2], rdy [2], bsy [2];
  exp_t q0 [$], q1 [$];
  int cyc = 0, checks = 0, fails = 0;
  bit cv [2];
  logic [31:0] ca [2], cb [2];
  bit cu [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  div_rem_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u0 (
    .clk(clk), .reset(reset), .acc_in_A(a_in[0]), .acc_in_B(b_in[0]),
    .div_rem_order(o_in[0]), .div_rem_order_active(act[0]), .kill(kil[0]),
    .div_rem_ready(rdy[0]), .div_rem_result(res[0]), .busy(bsy[0]));
  div_rem_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .EARLY_OUT(0)) u1 (
    .clk(clk), .reset(reset), .acc_in_A(a_in[1]), .acc_in_B(b_in[1]),
    .div_rem_order(o_in[1]), .div_rem_order_active(act[1]), .kill(kil[1]),
    .div_rem_ready(rdy[1]), .div_rem_result(res[1]), .busy(bsy[1]));
  function automatic logic [31:0] ref_fn(logic [31:0] a, logic [31:0] b, logic [1:0] o);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin q = '1; r = a; end
    else if (!o[0] && a == 32'h8000_0000 && b == '1) begin q = a; r = 0; end
    else if (!o[0]) begin q = 32'(sa / sb); r = 32'(sa % sb); end
    else begin q = a / b; r = a % b; end
    return o[1] ? r : q;
  endfunction
  function automatic int lat_fn(int d, logic [31:0] a, logic [31:0] b, logic [1:0] o);
    logic [31:0] aa, ab;
    aa = (!o[0] && a[31]) ? -a : a;
    ab = (!o[0] && b[31]) ? -b : b;
    if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == '1)) return 1;
    if (d == 0 && aa < ab) return 3;
    return d == 0 ? 35 : 11;
  endfunction
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic issue(int d, logic [31:0] a, logic [31:0] b, logic [1:0] o);
    bit hit;
    int n;
    exp_t e;
    hit = cv[d] && ca[d] == a && cb[d] == b && cu[d] == o[0];
    @(posedge clk);
    #1;
    a_in[d] = a;
    b_in[d] = b;
    o_in[d] = o;
    act[d] = 1;
    e.v = ref_fn(a, b, o);
    e.at = cyc + (hit ? 0 : lat_fn(d, a, b, o));
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    act[d] = 0;
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL timeout dut%0d a=%h b=%h ord=%0d got=no_ready exp=ready", d, a, b, o);
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end else if (!hit) begin
      cv[d] = 1;
      ca[d] = a;
      cb[d] = b;
      cu[d] = o[0];
    end
  endtask
  function automatic logic [31:0] pick_a();
    int s = $urandom_range(0, 9);
    return s == 0 ? 32'h8000_0000 : s == 1 ? 32'($urandom_range(0, 20)) :
           s == 2 ? -32'($urandom_range(0, 20)) : 32'($urandom);
  endfunction
  function automatic logic [31:0] pick_b();
    int s = $urandom_range(0, 9);
    return s == 0 ? 32'd0 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'($urandom_range(1, 20)) :
           s == 3 ? -32'($urandom_range(1, 20)) : s < 7 ? 32'($urandom) >> $urandom_range(0, 31) :
           32'($urandom);
  endfunction
  // scoreboard monitor: every ready must match the oldest expectation in value and cycle
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) if (rdy[d]) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready dut%0d got=%h exp=none", d, res[d]);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        checks += 2;
        if (res[d] !== e.v) begin
          fails++;
          $display("FAIL result dut%0d got=%h exp=%h", d, res[d], e.v);
        end
        if (cyc != e.at) begin
          fails++;
          $display("FAIL latency dut%0d got_cycle=%0d exp_cycle=%0d", d, cyc, e.at);
        end
      end
    end
  end
  initial begin
    logic [31:0] ra, rb;
    logic [1:0] ro;
    for (int d = 0; d < 2; d++) begin
      a_in[d] = 0; b_in[d] = 0; o_in[d] = 0; act[d] = 0; kil[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready%0d", d), 32'(rdy[d]), 0);
      chk($sformatf("reset_busy%0d", d), 32'(bsy[d]), 0);
      chk($sformatf("reset_result%0d", d), res[d], 0);
    end
    issue(0, -32'd7, 32'd2, ORD_DIV);
    issue(0, -32'd7, 32'd2, ORD_REM);
    issue(0, 32'h8000_0000, 0, ORD_DIVU);
    issue(0, 32'h8000_0000, 0, ORD_REMU);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, ORD_DIV);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, ORD_REM);
    issue(0, 32'd5, 32'd9, ORD_DIVU);
    issue(0, 32'd5, 32'd9, ORD_REMU);
    issue(1, 32'd5, 32'd9, ORD_DIVU);
    issue(1, 32'd5, 32'd9, ORD_REMU);
    // kill mid-operation: no ready, idle next cycle, cache untouched
    @(posedge clk);
    #1;
    a_in[0] = 100; b_in[0] = 7; o_in[0] = ORD_DIV; act[0] = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_kill", 32'(bsy[0]), 1);
    kil[0] = 1;
    act[0] = 0;
    @(negedge clk);
    chk("ready_during_kill", 32'(rdy[0]), 0);
    @(posedge clk);
    #1;
    kil[0] = 0;
    chk("busy_after_kill", 32'(bsy[0]), 0);
    issue(0, 32'd100, 32'd7, ORD_DIV);
    issue(0, 32'd100, 32'd7, ORD_REM);
    // reset mid-operation invalidates the cache
    issue(1, 32'd1000, 32'd33, ORD_DIVU);
    @(posedge clk);
    #1;
    a_in[1] = 55; b_in[1] = 3; o_in[1] = ORD_REM; act[1] = 1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    act[1] = 0;
    cv[0] = 0;
    cv[1] = 0;
    @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(rdy[1]), 0);
    chk("busy_in_reset", 32'(bsy[1]), 0);
    chk("result_in_reset", res[1], 0);
    reset = 0;
    issue(1, 32'd1000, 32'd33, ORD_REMU);
    for (int i = 0; i < 30; i++) begin
      ra = pick_a(); rb = pick_b(); ro = 2'($urandom_range(0, 3));
      issue(0, ra, rb, ro);
      if ($urandom_range(0, 1) == 1) issue(0, ra, rb, ro ^ 2'b10);
    end
    for (int i = 0; i < 60; i++) begin
      ra = pick_a(); rb = pick_b(); ro = 2'($urandom_range(0, 3));
      issue(1, ra, rb, ro);
      if ($urandom_range(0, 2) == 0) issue(1, ra, rb, ro ^ 2'b10);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations got=%0d exp=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
